clkmux_sel_ctrl: RTL and testbench

//  Glitch-safe select sequencer feeding the 4:1 no-glitch clock mux (drives its SEL_I/EN_I).

---
 rtl/clkmux_sel_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clkmux_sel_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clkmux_sel_ctrl.sv
// clkmux_sel_ctrl: glitch-safe select sequencer for a 4:1 no-glitch clock mux.
//
// A requested clock index is accepted through a valid/ready handshake. A switch then
// proceeds in three steps:
//   1. Gate the mux output off (EN_O low) and hold it off for OFF_CYCLES so the old
//      clock can drain.
//   2. Change SEL_O, then keep EN_O low for SETTLE_CYCLES so the new select settles.
//   3. Re-enable the mux and pulse DONE_O.
// A request for the index that is already selected is acknowledged without dropping
// EN_O. This block runs on an always-on control clock that is independent of the
// four muxed clocks. All outputs are registered.
//
// Build option CLKMUX_SEL_CTRL_PENDING_EN adds a one-entry pending slot. With it,
// REQ_READY_O stays high in every state except the post-reset settle. A request
// accepted while busy overwrites the slot, so the last one wins.
//
// Ports:
//   CLK_I        in   control clock, rising edge
//   NRST_I       in   asynchronous active-low reset
//   REQ_SEL_I    in   [1:0] requested mux input index
//   REQ_VALID_I  in   request valid
//   REQ_READY_O  out  request accepted on an edge where VALID & READY
//   SEL_O        out  [1:0] to mux SEL_I
//   EN_O         out  to mux EN_I
//   BUSY_O       out  high whenever the FSM is not idle
//   DONE_O       out  one-cycle pulse: switch complete, EN_O back high
module clkmux_sel_ctrl #(
  parameter int unsigned OFF_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [1:0]  RST_SEL       = 2'b00
) (
  input  logic       CLK_I,
  input  logic       NRST_I,
  input  logic [1:0] REQ_SEL_I,
  input  logic       REQ_VALID_I,
  output logic       REQ_READY_O,
  output logic [1:0] SEL_O,
  output logic       EN_O,
  output logic       BUSY_O,
  output logic       DONE_O
);

  localparam int unsigned CntMax = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StOff, StSettle} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         tgt_q, tgt_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  // boot_q marks the post-reset settle: it must not pulse DONE_O or accept requests.
  logic               boot_q, boot_d;
  // ack_q: a same-index request was accepted; DONE_O fires on the following edge.
  logic               ack_q, ack_d;
  logic               accept;
  logic               start;
  logic [1:0]         start_sel;
`ifdef CLKMUX_SEL_CTRL_PENDING_EN
  logic               slot_vld_q, slot_vld_d;
  logic [1:0]         slot_sel_q, slot_sel_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    tgt_d     = tgt_q;
    en_d      = en_q;
    boot_d    = boot_q;
    done_d    = 1'b0;
    ack_d     = 1'b0;
    start     = 1'b0;
    start_sel = sel_q;
    accept    = REQ_VALID_I & ready_q;
`ifdef CLKMUX_SEL_CTRL_PENDING_EN
    slot_vld_d = slot_vld_q;
    slot_sel_d = slot_sel_q;
`endif

    unique case (state_q)
      StIdle: begin
        done_d = ack_q;
`ifdef CLKMUX_SEL_CTRL_PENDING_EN
        // While an acknowledge is still in flight, new work waits one edge.
        // Starting now would drop EN_O in the same cycle DONE_O is high.
        if (!ack_q) begin
          if (slot_vld_q) begin
            start      = 1'b1;
            start_sel  = slot_sel_q;
            slot_vld_d = 1'b0;
          end else if (accept) begin
            start     = 1'b1;
            start_sel = REQ_SEL_I;
          end
        end
        if (accept && (ack_q || slot_vld_q)) begin
          slot_vld_d = 1'b1;
          slot_sel_d = REQ_SEL_I;
        end
`else
        if (accept) begin
          start     = 1'b1;
          start_sel = REQ_SEL_I;
        end
`endif
        if (start) begin
          if (start_sel != sel_q) begin
            state_d = StOff;
            cnt_d   = CNT_W'(OFF_CYCLES - 1);
            tgt_d   = start_sel;
            en_d    = 1'b0;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      StOff: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          sel_d   = tgt_q;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          en_d    = 1'b1;
          done_d  = ~boot_q;
          boot_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StSettle;
    endcase

`ifdef CLKMUX_SEL_CTRL_PENDING_EN
    if (accept && (state_q != StIdle)) begin
      slot_vld_d = 1'b1;
      slot_sel_d = REQ_SEL_I;
    end
    ready_d = ~boot_d;
`else
    ready_d = (state_d == StIdle) && !ack_d;
`endif
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q <= StSettle;
      cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
      sel_q   <= RST_SEL;
      tgt_q   <= RST_SEL;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      boot_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      boot_q  <= boot_d;
      ack_q   <= ack_d;
    end
  end

`ifdef CLKMUX_SEL_CTRL_PENDING_EN
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      slot_vld_q <= 1'b0;
      slot_sel_q <= 2'b00;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_sel_q <= slot_sel_d;
    end
  end
`endif

  assign REQ_READY_O = ready_q;
  assign SEL_O       = sel_q;
  assign EN_O        = en_q;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;

endmodule

// File: tb/tb_clkmux_sel_ctrl.sv
// Directed self-checking bench for clkmux_sel_ctrl with the default parameters
// (OFF_CYCLES = 8, SETTLE_CYCLES = 4, RST_SEL = 0). The pending-slot scenario is
// exercised only when CLKMUX_SEL_CTRL_PENDING_EN is defined.
module tb_clkmux_sel_ctrl;

`ifdef CLKMUX_SEL_CTRL_PENDING_EN
  localparam bit Pend = 1'b1;
`else
  localparam bit Pend = 1'b0;
`endif

  logic       clk;
  logic       nrst;
  logic [1:0] req_sel;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] sel;
  logic       en;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  clkmux_sel_ctrl dut (
    .CLK_I       (clk),
    .NRST_I      (nrst),
    .REQ_SEL_I   (req_sel),
    .REQ_VALID_I (req_valid),
    .REQ_READY_O (req_ready),
    .SEL_O       (sel),
    .EN_O        (en),
    .BUSY_O      (busy),
    .DONE_O      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one control edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release reset and check the 4-edge boot settle.
  task automatic release_and_boot();
    nrst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("boot_en_%0d", i), 32'(en), 32'(i == 4));
      chk($sformatf("boot_sel_%0d", i), 32'(sel), 32'd0);
      chk($sformatf("boot_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("boot_busy_%0d", i), 32'(busy), 32'(i != 4));
    end
    chk("boot_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    bit saw3;
    nrst      = 1'b1;
    req_sel   = 2'd0;
    req_valid = 1'b0;
    #2 nrst = 1'b0;
    #1 check_reset_vals("rst");
    step();
    step();

    // 1: reset release
    release_and_boot();

    // 2: switch 0 -> 2
    req_sel   = 2'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sw_en_k", 32'(en), 32'd0);
    chk("sw_busy_k", 32'(busy), 32'd1);
    chk("sw_ready_k", 32'(req_ready), 32'(Pend));
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("sw_sel_%0d", i), 32'(sel), (i >= 8) ? 32'd2 : 32'd0);
      chk($sformatf("sw_en_%0d", i), 32'(en), 32'(i == 12));
      chk($sformatf("sw_done_%0d", i), 32'(done), 32'(i == 12));
    end
    step();
    chk("sw_done_after", 32'(done), 32'd0);

    // 3: same-index request
    req_sel   = 2'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("same_en_k", 32'(en), 32'd1);
    chk("same_done_k", 32'(done), 32'd0);
    step();
    chk("same_done_k1", 32'(done), 32'd1);
    chk("same_en_k1", 32'(en), 32'd1);
    chk("same_sel_k1", 32'(sel), 32'd2);
    step();
    chk("same_done_k2", 32'(done), 32'd0);

`ifndef CLKMUX_SEL_CTRL_PENDING_EN
    // 4: VALID held across a switch; REQ_SEL_I changes after accept
    req_sel   = 2'd1;
    req_valid = 1'b1;
    step();
    req_sel = 2'd3;
    chk("hold_en_k", 32'(en), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'(i == 12));
      if (i == 8) chk("hold_sel_8", 32'(sel), 32'd1);
    end
    chk("hold_done_12", 32'(done), 32'd1);
    step();
    req_valid = 1'b0;
    chk("hold_en_2nd", 32'(en), 32'd0);
    chk("hold_done_2nd", 32'(done), 32'd0);
    for (int i = 1; i <= 12; i++) step();
    chk("hold_sel_fin", 32'(sel), 32'd3);
    chk("hold_en_fin", 32'(en), 32'd1);
    chk("hold_done_fin", 32'(done), 32'd1);
    step();
`endif

    // 5: reset mid-switch
    req_sel   = 2'd1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) step();
    chk("mid_en_pre", 32'(en), 32'd0);
    nrst = 1'b0;
    #1 check_reset_vals("mid");
    step();
    check_reset_vals("mid_held");
    release_and_boot();

`ifdef CLKMUX_SEL_CTRL_PENDING_EN
    // 6: requests 1, 3, 2 while busy; 3 is overwritten by 2
    dones = 0;
    saw3  = 1'b0;
    req_sel   = 2'd1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      if (i == 2 || i == 4) begin
        req_sel   = (i == 2) ? 2'd3 : 2'd2;
        req_valid = 1'b1;
      end
      step();
      req_valid = 1'b0;
      if (done) dones++;
      if (sel == 2'd3) saw3 = 1'b1;
      if (i == 12) begin
        chk("pend_sel_12", 32'(sel), 32'd1);
        chk("pend_done_12", 32'(done), 32'd1);
      end
      if (i == 13) chk("pend_en_13", 32'(en), 32'd0);
      if (i == 21) chk("pend_sel_21", 32'(sel), 32'd2);
      if (i == 25) chk("pend_done_25", 32'(done), 32'd1);
    end
    chk("pend_dones", 32'(dones), 32'd2);
    chk("pend_no_sel3", 32'(saw3), 32'd0);
    chk("pend_sel_fin", 32'(sel), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
